// File: rtl/demux_1_2_reg_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer: channel state
// encoding and default word/counter widths.
package demux_1_2_reg_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux_1_2_reg_chan.sv
// One output channel of the demux: a single-word holding register with an
// EMPTY/FULL state machine and a wrapping count of delivered words.
module demux_chan_reg
    import demux_1_2_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             state_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deliver;

    // load_i is only raised when the channel is EMPTY or delivering this
    // edge, so an overwrite here never loses an undelivered word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        deliver = (state_q == FULL) && out_ready_i;

        case (state_q)
            EMPTY: begin
                if (load_i) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (deliver && !load_i) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (load_i) begin
            data_d = load_data_i;
        end
        if (deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = (state_q == FULL);
    assign cnt_o       = cnt_q;
    assign state_o     = state_q;

endmodule

// File: rtl/demux_1_2_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted source word into the
// channel chosen by sel; each channel holds it until its sink takes it.
module demux_1_2_reg
    import demux_1_2_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic             out0_valid,
    output logic             out1_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic state0, state1;
    logic accept, load0, load1;

    // Ready depends only on the selected channel, so a stalled channel
    // never blocks traffic bound for the other one.
    always_comb begin
        if (sel) begin
            in_ready = (state1 == EMPTY) || out1_ready;
        end else begin
            in_ready = (state0 == EMPTY) || out0_ready;
        end
        accept = in_valid && in_ready;
        load0  = accept && !sel;
        load1  = accept && sel;
    end

    demux_chan_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_chan0 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load0),
        .load_data_i(in_data),
        .out_ready_i(out0_ready),
        .out_data_o (out0_data),
        .out_valid_o(out0_valid),
        .cnt_o      (cnt0),
        .state_o    (state0)
    );

    demux_chan_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_chan1 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load1),
        .load_data_i(in_data),
        .out_ready_i(out1_ready),
        .out_data_o (out1_data),
        .out_valid_o(out1_valid),
        .cnt_o      (cnt1),
        .state_o    (state1)
    );

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Bench for demux_1_2_reg: per-channel word queues and delivery counts form
// the reference; a monitor compares every presented word against them.
module tb_demux_1_2_reg;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data, out1_data;
    logic       out0_valid, out1_valid;
    logic       out0_ready, out1_ready;
    logic [7:0] cnt0, cnt1;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] m_cnt0, m_cnt1;
    int         n_vec;
    int         n_err;
    logic       acc;

    demux_1_2_reg #(
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out0_valid(out0_valid),
        .out1_valid(out1_valid),
        .out0_ready(out0_ready),
        .out1_ready(out1_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
    endtask

    // Called at posedge+1; applies inputs for one clock and returns at the
    // next posedge+1, so every edge's inputs are recorded exactly once.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1, output logic accepted);
        logic exp_rdy;
        in_valid   = v;
        sel        = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        #1;
        exp_rdy = s ? ((exp_q1.size() == 0) || r1) : ((exp_q0.size() == 0) || r0);
        chk("in_ready", in_ready, exp_rdy);
        accepted = in_ready;
        if (v && exp_rdy) begin
            if (s) exp_q1.push_back(d);
            else   exp_q0.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        sel        = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares pre-edge outputs with the reference, then retires
    // whatever the upcoming edge delivers.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out0_valid", out0_valid, exp_q0.size() != 0);
            chk("out1_valid", out1_valid, exp_q1.size() != 0);
            if (exp_q0.size() != 0 && out0_valid) chk("out0_data", out0_data, exp_q0[0]);
            if (exp_q1.size() != 0 && out1_valid) chk("out1_data", out1_data, exp_q1[0]);
            chk("cnt0", cnt0, m_cnt0);
            chk("cnt1", cnt1, m_cnt1);
            if (exp_q0.size() != 0 && out0_ready) begin
                void'(exp_q0.pop_front());
                m_cnt0 = m_cnt0 + 8'd1;
            end
            if (exp_q1.size() != 0 && out1_ready) begin
                void'(exp_q1.pop_front());
                m_cnt1 = m_cnt1 + 8'd1;
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        sel        = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        clear_model();
        #3;
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic routing
        cycle(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, acc);
        chk("route_v0", out0_valid, 1);
        chk("route_d0", out0_data, 8'h3C);
        cycle(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, acc);
        chk("route_v1", out1_valid, 1);
        chk("route_d1", out1_data, 8'hC3);
        chk("route_cnt0", cnt0, 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("route_cnt0b", cnt0, 1);
        chk("route_cnt1", cnt1, 1);

        // Reset asserted while channel 0 holds a word
        cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("mid_v0_pre", out0_valid, 1);
        chk("mid_d0_pre", out0_data, 8'hA5);
        rst = 1'b1;
        clear_model();
        #1;
        chk("mid_v0", out0_valid, 0);
        chk("mid_d0", out0_data, 0);
        chk("mid_cnt0", cnt0, 0);
        chk("mid_cnt1", cnt1, 0);
        sel = 1'b0;
        #1;
        chk("mid_rdy_s0", in_ready, 1);
        sel = 1'b1;
        #1;
        chk("mid_rdy_s1", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure on channel 0
        cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, acc);
        chk("bp_first_acc", acc, 1);
        cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, acc);
        chk("bp_refused", acc, 0);
        chk("bp_hold", out0_data, 8'h11);
        cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, acc);
        chk("bp_other_acc", acc, 1);
        chk("bp_hold2", out0_data, 8'h11);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Full throughput on channel 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, acc);
            chk("thr_acc", acc, 1);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("thr_cnt0", cnt0, 16);

        // Simultaneous delivery on both channels
        do_reset();
        cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, acc);
        chk("sim_v0_full", out0_valid, 1);
        chk("sim_v1_full", out1_valid, 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("sim_v0_clr", out0_valid, 0);
        chk("sim_v1_clr", out1_valid, 0);
        chk("sim_cnt0", cnt0, 1);
        chk("sim_cnt1", cnt1, 1);

        // Counter wrap on channel 1
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, acc);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, acc);
        chk("wrap_cnt1", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);
        chk("wrap_v1", out1_valid, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, acc);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("end_v0", out0_valid, 0);
        chk("end_v1", out1_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1_2_reg.md
DEMUX_1_2_REG -- requirements
Module: demux_1_2_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of each delivered-word counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: source word.
REQ-006 SHALL have port sel, input, 1 bit: destination select, 0 for channel 0 and 1 for channel 1, sampled with in_data.
REQ-007 SHALL have port in_valid, input, 1 bit: source offers a word.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-009 SHALL have ports out0_data and out1_data, output, WIDTH bits each: held channel words.
REQ-010 SHALL have ports out0_valid and out1_valid, output, 1 bit each: the channel holds a word.
REQ-011 SHALL have ports out0_ready and out1_ready, input, 1 bit each: the sink takes the word.
REQ-012 SHALL have ports cnt0 and cnt1, output, CNT_W bits each: words delivered per channel.

Function
REQ-013 SHALL accept a word (transfer in) when in_valid and in_ready are both 1 at a rising clk edge.
REQ-014 SHALL drive in_ready = ~outS_valid | outS_ready, where S = sel; the path is combinational from sel and the selected channel state only.
REQ-015 SHALL load an accepted word into channel S only; the unselected channel's data and valid SHALL be unchanged.
REQ-016 SHALL present an accepted word at outS_data with outS_valid=1 on the cycle after acceptance: 1-cycle latency.
REQ-017 SHALL hold outN_data stable while outN_valid=1 and outN_ready=0.
REQ-018 SHALL complete a delivery on channel N when outN_valid and outN_ready are both 1 at an edge; outN_valid SHALL clear unless a new word is loaded into N on the same edge.
REQ-019 SHALL, on simultaneous delivery and load of the same channel, keep outN_valid=1 and replace outN_data with the new word, giving full throughput of one word per cycle.
REQ-020 SHALL allow channel 0 and channel 1 to deliver on the same edge independently.
REQ-021 SHALL increment cntN by 1 on each completed delivery on channel N and wrap from 2^CNT_W-1 to 0.
REQ-022 SHALL implement each channel as a two-state machine: EMPTY, then FULL on load; FULL to EMPTY on delivery without load; FULL stays FULL on delivery with load or on a stall.
REQ-023 SHALL ignore in_data and sel when in_valid=0; no state change results.
REQ-024 SHALL never drop or duplicate a word: every accepted word is delivered exactly once, in acceptance order within its channel.

Reset
REQ-025 SHALL, while rst=1, immediately force out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0, and both channels to EMPTY.
REQ-026 SHALL discard any held word when rst asserts mid-operation; no delivery is counted for it.
REQ-027 SHALL drive in_ready=1 out of reset (both channels EMPTY) and resume normal operation on the first edge after rst deasserts.

Structure
REQ-028 SHALL take the channel state encodings (EMPTY=0, FULL=1) and the default WIDTH/CNT_W values from the processor's shared constants package.
REQ-029 SHALL be built from two instances of sub-module demux_chan_reg, each containing one channel's holding register, state machine and delivery counter; the top level contains only the select steering and the in_ready logic.

Verification
REQ-030 Bench SHALL check reset: assert rst mid-stream while out0_valid=1 holding 8'hA5 -> out0_valid=0, data=0, cnt0=0 immediately; in_ready=1 once sel is applied.
REQ-031 Bench SHALL check basic routing: send 8'h3C with sel=0, then 8'hC3 with sel=1, both sinks ready -> out0_data=3C the cycle after the first, out1_data=C3 the cycle after the second; cnt0=cnt1=1.
REQ-032 Bench SHALL check backpressure: out0_ready=0, send 8'h11 and then 8'h22 on sel=0 -> 8'h22 is refused (in_ready=0) and out0_data stays 11; a sel=1 word is still accepted.
REQ-033 Bench SHALL check full throughput: 16 consecutive sel=0 words 0..15 with out0_ready=1 every cycle -> in_ready is held at 1, the words arrive in order with one per cycle, and cnt0=16.
REQ-034 Bench SHALL check wrap-around: 256 deliveries on channel 1 -> cnt1 returns to 0 and cnt0 is unchanged.
REQ-035 Bench SHALL check simultaneous delivery on both channels: both channels FULL and both readies set in one cycle -> both valids clear together and both counters increment.
